// File: rtl/handshakes_delay_ready.sv
// Two-entry registered ready/valid stage: main register drives the output, a skid
// register absorbs the one word accepted while the downstream is stalled.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | nothing held; up_ready=1, down_valid=0
// BUSY  | one word in main; up_ready=1, down_valid=1
// FULL  | main and skid both held; up_ready=0, down_valid=1
module handshakes_delay_ready #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_valid,
  input  logic [WORD_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  input  logic                  down_ready,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] main_q, main_d;
  logic [WORD_WIDTH-1:0] skid_q, skid_d;
  logic                  up_ready_q, up_ready_d;
  logic                  down_valid_q, down_valid_d;
  logic [1:0]            occ_q, occ_d;
  logic                  up_xfer, dn_xfer;

  // Handshakes use only registered outputs, so no input-to-output comb path exists.
  assign up_xfer = up_valid & up_ready_q;
  assign dn_xfer = down_valid_q & down_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      up_ready_q   <= 1'b1;
      down_valid_q <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      up_ready_q   <= up_ready_d;
      down_valid_q <= down_valid_d;
      occ_q        <= occ_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          main_d  = up_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (up_xfer && dn_xfer) begin
          main_d = up_data;
        end else if (up_xfer) begin
          skid_d  = up_data;
          state_d = FULL;
        end else if (dn_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (dn_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flag flops are decoded from the next state so they track state_q exactly.
    up_ready_d   = (state_d != FULL);
    down_valid_d = (state_d != EMPTY);
    occ_d        = state_d;
  end

  assign up_ready   = up_ready_q;
  assign down_valid = down_valid_q;
  assign down_data  = main_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_handshakes_delay_ready.sv
// Directed and randomized checks of handshakes_delay_ready against a queue model.
module tb_handshakes_delay_ready;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_valid;
  logic [31:0] up_data;
  logic        up_ready;
  logic        down_valid;
  logic [31:0] down_data;
  logic        down_ready;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  handshakes_delay_ready #(.WORD_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic r, input logic [1:0] occ);
    chk({tag, ".valid"}, {31'd0, down_valid}, {31'd0, v});
    if (v) chk({tag, ".data"}, down_data, d);
    chk({tag, ".ready"}, {31'd0, up_ready}, {31'd0, r});
    chk({tag, ".occ"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  logic [31:0] q[$];
  logic [31:0] prev_data;
  logic        stalled;
  logic        up_x, dn_x;
  int          cnt;

  initial begin
    rst_n = 1'b0; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
    #12;
    chk("rst.valid", {31'd0, down_valid}, 32'd0);
    chk("rst.ready", {31'd0, up_ready}, 32'd1);
    chk("rst.occ", {30'd0, occupancy}, 32'd0);
    chk("rst.data", down_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single word
    up_valid = 1'b1; up_data = 32'hA5; down_ready = 1'b1;
    tick();
    chk_out("single1", 1'b1, 32'hA5, 1'b1, 2'd1);
    up_valid = 1'b0;
    tick();
    chk_out("single2", 1'b0, 32'h0, 1'b1, 2'd0);

    // back-to-back stream
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1; up_data = i;
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, i, 1'b1, 2'd1);
    end
    up_valid = 1'b0;
    tick();
    chk_out("stream_end", 1'b0, 32'h0, 1'b1, 2'd0);

    // backpressure fill
    down_ready = 1'b0;
    up_valid = 1'b1; up_data = 32'h11;
    tick();
    chk_out("bp11", 1'b1, 32'h11, 1'b1, 2'd1);
    up_data = 32'h22;
    tick();
    chk_out("bp22", 1'b1, 32'h11, 1'b0, 2'd2);
    up_data = 32'h33;
    tick();
    chk_out("bp33held", 1'b1, 32'h11, 1'b0, 2'd2);
    down_ready = 1'b1;
    tick();
    chk_out("drain22", 1'b1, 32'h22, 1'b1, 2'd1);
    tick();
    chk_out("drain33", 1'b1, 32'h33, 1'b1, 2'd1);
    up_valid = 1'b0;
    tick();
    chk_out("drain_end", 1'b0, 32'h0, 1'b1, 2'd0);

    // simultaneous transfer in BUSY
    down_ready = 1'b0; up_valid = 1'b1; up_data = 32'h10;
    tick();
    chk_out("sim10", 1'b1, 32'h10, 1'b1, 2'd1);
    down_ready = 1'b1; up_data = 32'h77;
    tick();
    chk_out("sim77", 1'b1, 32'h77, 1'b1, 2'd1);
    up_valid = 1'b0;
    tick();
    chk_out("sim_end", 1'b0, 32'h0, 1'b1, 2'd0);

    // async reset while full
    down_ready = 1'b0; up_valid = 1'b1; up_data = 32'hC1;
    tick();
    up_data = 32'hC2;
    tick();
    chk_out("prerst", 1'b1, 32'hC1, 1'b0, 2'd2);
    up_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, down_valid}, 32'd0);
    chk("arst.ready", {31'd0, up_ready}, 32'd1);
    chk("arst.occ", {30'd0, occupancy}, 32'd0);
    chk("arst.data", down_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_out("postrst", 1'b0, 32'h0, 1'b1, 2'd0);
    down_ready = 1'b1; up_valid = 1'b1; up_data = 32'h5A;
    tick();
    chk_out("first5A", 1'b1, 32'h5A, 1'b1, 2'd1);
    up_valid = 1'b0;
    tick();
    chk_out("after5A", 1'b0, 32'h0, 1'b1, 2'd0);

    // random traffic against a queue model
    q.delete();
    stalled = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 10000; c++) begin
      cnt = q.size();
      chk("rnd.ready", {31'd0, up_ready}, {31'd0, cnt != 2});
      chk("rnd.valid", {31'd0, down_valid}, {31'd0, cnt != 0});
      chk("rnd.occ", {30'd0, occupancy}, cnt);
      if (cnt != 0) chk("rnd.data", down_data, q[0]);
      if (stalled) chk("rnd.stable", down_data, prev_data);
      up_valid   = $urandom_range(0, 1) == 1;
      down_ready = $urandom_range(0, 1) == 1;
      up_data    = $urandom;
      up_x = up_valid && (cnt != 2);
      dn_x = (cnt != 0) && down_ready;
      stalled   = (cnt != 0) && !down_ready;
      prev_data = down_data;
      if (dn_x) void'(q.pop_front());
      if (up_x) q.push_back(up_data);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/handshakes_delay_ready.md
HANDSHAKES_DELAY_READY -- requirements
Module: handshakes_delay_ready

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, the payload width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port up_valid  input  1  upstream word present.
REQ-005 SHALL have port up_data  input  WORD_WIDTH  upstream payload.
REQ-006 SHALL have port up_ready  output  1  block can accept a word; driven directly from a flop.
REQ-007 SHALL have port down_valid  output  1  downstream word present; driven from a flop.
REQ-008 SHALL have port down_data  output  WORD_WIDTH  downstream payload; driven from a flop.
REQ-009 SHALL have port down_ready  input  1  downstream accepts the word.
REQ-010 SHALL have port occupancy  output  2  words held: 0, 1 or 2; driven from flops.

Function
REQ-011 SHALL register the ready (backpressure) path so that no combinational path exists from down_ready to up_ready, or from up_* to down_*.
REQ-012 SHALL define up-transfer as up_valid & up_ready and down-transfer as down_valid & down_ready, both sampled at the rising clk edge.
REQ-013 SHALL hold a main register (drives down_data) and one skid register, and SHALL run a 3-state FSM: EMPTY (occupancy 0), BUSY (1), FULL (2).
REQ-014 SHALL drive up_ready = 1 in EMPTY and BUSY and 0 in FULL, and down_valid = 1 in BUSY and FULL.
REQ-015 EMPTY: on up-transfer, main <= up_data and go to BUSY; otherwise stay.
REQ-016 BUSY with up-transfer and down-transfer: main <= up_data and stay in BUSY, giving full throughput.
REQ-017 BUSY with up-transfer and no down-transfer: skid <= up_data and go to FULL.
REQ-018 BUSY with down-transfer and no up-transfer: go to EMPTY.
REQ-019 BUSY with neither transfer: hold.
REQ-020 FULL with down-transfer: main <= skid and go to BUSY; otherwise hold.
REQ-021 FULL: up_valid SHALL be ignored and up_data never captured.
REQ-022 SHALL give latency of 1 cycle from up-transfer to the word appearing on down_valid/down_data when the downstream is not stalled.
REQ-023 SHALL sustain 1 word/cycle while down_ready is held at 1.
REQ-024 SHALL keep down_data stable and down_valid high while down_valid & !down_ready.
REQ-025 SHALL deliver words in acceptance order with no loss or duplication.
REQ-026 SHALL assert up_ready again in the cycle after the FULL-state down-transfer.
REQ-027 SHALL update occupancy in the same cycle as the state change, always equal to the state encoding.
REQ-028 SHALL leave down_data and skid contents unchanged when not written; no arithmetic wrap is needed.

Reset
REQ-029 On rst_n low, SHALL immediately (asynchronously) set state EMPTY, down_valid 0, up_ready 1, occupancy 0, and main and skid to 0.
REQ-030 Reset asserted mid-operation SHALL discard all held words; the first up-transfer after release SHALL be the next word delivered.
REQ-031 SHALL not perform an up-transfer or down-transfer while rst_n is low.

Verification
REQ-032 Scenario: reset, then up_valid=1 with data 0xA5 for one cycle and down_ready=1 -> down_valid=1 and down_data=0xA5 next cycle, then down_valid=0; occupancy 0->1->0.
REQ-033 Scenario: stream 0x1..0x8 back-to-back with down_ready=1 -> 0x1..0x8 out on consecutive cycles with 1-cycle latency; up_ready never drops.
REQ-034 Scenario: down_ready=0, offer 0x11, 0x22, 0x33 -> 0x11, 0x22 accepted, occupancy=2, up_ready=0, and 0x33 held upstream; then down_ready=1 -> output 0x11, 0x22, 0x33 in order.
REQ-035 Scenario: random up_valid/down_ready at 50% for 10k cycles -> scoreboard order exact; up_ready == (occupancy != 2); down_data stable while stalled.
REQ-036 Scenario: occupancy=2, then pulse rst_n low asynchronously mid-cycle -> outputs go to reset values before the next edge; next word 0x5A comes out first after release.
REQ-037 Scenario: in BUSY, up-transfer 0x77 coincides with down-transfer -> stay BUSY, down_data=0x77 next cycle, skid unused.
